// File: rtl/heap_pkg.sv
// Shared definitions for the keypoint heap sorter and its sequencer:
// sequencer state encoding, heap capacity, and the record key extractor.
package heap_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_ENDP  = 3'd3;
    localparam logic [2:0] S_SORT  = 3'd4;
    localparam logic [2:0] S_FLUSH = 3'd5;
    localparam logic [2:0] S_DRAIN = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam int REC_W = 292;
    localparam int KEY_W = 7;

    // Two sub-heaps, each a full binary tree of NLEVELS-1 levels.
    function automatic int unsigned heap_cap(input int unsigned nlevels);
        return 2 * ((32'd1 << (nlevels - 1)) - 1);
    endfunction

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [KEY_W-1:0] key_of(input logic [REC_W-1:0] rec);
        return rec[KEY_W-1:0];
    endfunction

endpackage

// File: rtl/heap_out_reg.sv
// One-entry output register with valid/ready handshake; captures a record when
// told to and reports whether a capture can be taken this cycle.
module heap_out_reg #(
    parameter int DATA_WIDTH = 292
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  last,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  can_accept
);

    assign can_accept = !m_valid || m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (capture) begin
            m_data  <= din;
            m_valid <= 1'b1;
            m_last  <= last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/heap_sort_ctrl.sv
// Sequencer for one heap sort job: clear, load, end-of-input, wait for sort,
// then drain min(topk, loaded) records through a backpressured output register.
module heap_sort_ctrl
    import heap_pkg::*;
#(
    parameter int DATA_WIDTH   = 292,
    parameter int KEY_WIDTH    = 7,
    parameter int NLEVELS      = 6,
    parameter int CNT_WIDTH    = 16,
    parameter int SORT_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  cfg_topk,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] heap_din,
    output logic                  heap_en,
    output logic                  heap_init,
    output logic                  heap_in_end,
    output logic                  heap_flush,
    input  logic [DATA_WIDTH-1:0] heap_dout,
    input  logic                  heap_sort_end,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout
);

    localparam logic [CNT_WIDTH-1:0] CAP      = CNT_WIDTH'(heap_cap(NLEVELS));
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam int                   TW       = $clog2(SORT_TIMEOUT) + 1;
    localparam logic [TW-1:0]        TMO_LAST = TW'(SORT_TIMEOUT - 1);
    localparam logic [TW-1:0]        TMO_ONE  = TW'(1);

    logic [2:0]           state;
    logic                 init_second;
    logic [CNT_WIDTH-1:0] topk;
    logic [CNT_WIDTH-1:0] in_cnt;
    logic [CNT_WIDTH-1:0] out_cnt;
    logic [CNT_WIDTH-1:0] n_out;
    logic [TW-1:0]        tmo_cnt;
    logic                 accept;
    logic                 flush_go;
    logic                 can_accept;
    logic                 last_flush;

    assign n_out      = CNT_WIDTH'(umin(32'(topk), 32'(in_cnt)));
    assign s_ready    = (state == S_LOAD);
    assign accept     = s_valid && s_ready;
    assign heap_en    = accept;
    assign heap_din   = accept ? s_data : '0;
    assign heap_init  = (state == S_INIT);
    assign heap_in_end = (state == S_ENDP);
    // Never pull from the heap while the output register holds an unaccepted record.
    assign flush_go   = (state == S_FLUSH) && (out_cnt < n_out) && can_accept;
    assign heap_flush = flush_go;
    assign last_flush = ((out_cnt + CNT_ONE) == n_out);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    heap_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .capture    (flush_go),
        .din        (heap_dout),
        .last       (last_flush),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .can_accept (can_accept)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            init_second <= 1'b0;
            topk        <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    topk        <= cfg_topk;
                    err_timeout <= 1'b0;
                    in_cnt      <= '0;
                    out_cnt     <= '0;
                    init_second <= 1'b0;
                    state       <= S_INIT;
                end
                S_INIT: begin
                    init_second <= 1'b1;
                    if (init_second) state <= S_LOAD;
                end
                // in_cnt is bounded by CAP, so it cannot wrap.
                S_LOAD: if (accept) begin
                    in_cnt <= in_cnt + CNT_ONE;
                    if (s_last || (in_cnt + CNT_ONE) == CAP) state <= S_ENDP;
                end
                S_ENDP: begin
                    tmo_cnt <= '0;
                    state   <= S_SORT;
                end
                S_SORT: begin
                    if (heap_sort_end) begin
                        state <= S_FLUSH;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end
                S_FLUSH: begin
                    if (flush_go) begin
                        out_cnt <= out_cnt + CNT_ONE;
                        if (last_flush) state <= S_DRAIN;
                    end else if (n_out == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DRAIN: if (m_valid && m_ready) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // A stalled output record must not change under the consumer.
    property p_out_stable;
        @(posedge clk) disable iff (rst)
            (m_valid && !m_ready) |=> (m_valid && m_data[KEY_WIDTH-1:0] == $past(m_data[KEY_WIDTH-1:0]));
    endproperty
    assert property (p_out_stable);

endmodule

// File: tb/tb_heap_sort_ctrl.sv
// Bench for heap_sort_ctrl: behavioural heap, random jobs, and a scoreboard
// monitor comparing every accepted output record against a top-K reference.
module tb_heap_sort_ctrl;
    import heap_pkg::*;

    localparam int DW  = 292;
    localparam int KW  = 7;
    localparam int CW  = 16;
    localparam int CAP = 62;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] cfg_topk;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b1;
    logic [DW-1:0] heap_din;
    logic          heap_en;
    logic          heap_init;
    logic          heap_in_end;
    logic          heap_flush;
    logic [DW-1:0] heap_dout = '0;
    logic          heap_sort_end = 1'b0;
    logic          busy;
    logic          done;
    logic          err_timeout;

    heap_sort_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_topk      (cfg_topk),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .heap_din      (heap_din),
        .heap_en       (heap_en),
        .heap_init     (heap_init),
        .heap_in_end   (heap_in_end),
        .heap_flush    (heap_flush),
        .heap_dout     (heap_dout),
        .heap_sort_end (heap_sort_end),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   rdy_ph = 0;
    bit   no_sort = 1'b0;
    int   sort_cd = 0;
    int   n_flush = 0, n_en = 0, n_init = 0, n_inend = 0, n_out_seen = 0;
    int   last_acc_cyc = 0, inend_cyc = 0;
    exp_t exp_q[$];
    logic [DW-1:0] recs[$];
    int   bkeys[10] = '{3, 9, 1, 7, 5, 8, 2, 6, 4, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got key %0d data %h, expected key %0d data %h",
                     name, act[KW-1:0], act, exp[KW-1:0], exp);
        end
    endtask

    task automatic fail_now(input string name, input int val);
        n_chk++;
        n_fail++;
        $display("FAIL %s: observed %0d, none allowed", name, val);
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       begin m_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3); rdy_ph++; end
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Behavioural heap: kept sorted by descending key, equal keys in arrival order.
    logic [DW-1:0] hq[$];
    always begin
        logic          op_init, op_en, op_fl, op_end;
        logic [DW-1:0] din, tmp;
        int            p;
        @(negedge clk);
        op_init = heap_init;
        op_en   = heap_en;
        op_fl   = heap_flush;
        op_end  = heap_in_end;
        din     = heap_din;
        @(posedge clk);
        #1;
        if (op_init) hq.delete();
        if (op_en) begin
            p = hq.size();
            for (int j = 0; j < hq.size(); j++) begin
                tmp = hq[j];
                if (tmp[KW-1:0] < din[KW-1:0]) begin
                    p = j;
                    break;
                end
            end
            hq.insert(p, din);
        end
        if (op_fl && hq.size() > 0) void'(hq.pop_front());
        heap_sort_end = 1'b0;
        if (sort_cd > 0) begin
            sort_cd--;
            if (sort_cd == 0) heap_sort_end = 1'b1;
        end
        if (op_end && !no_sort) sort_cd = $urandom_range(1, 6);
        if (hq.size() > 0) heap_dout = hq[0];
        else heap_dout = '0;
    end

    // Scoreboard monitor and per-cycle protocol checks.
    always @(negedge clk) begin
        exp_t e;
        if (heap_init) n_init++;
        if (heap_en) n_en++;
        if (heap_in_end) begin
            n_inend++;
            inend_cyc = cyc;
            check("en_with_in_end", 64'(heap_en), 0);
        end
        if (heap_flush) begin
            n_flush++;
            check("flush_while_full", 64'(m_valid && !m_ready), 0);
        end
        if (m_valid && m_ready) begin
            n_out_seen++;
            last_acc_cyc = cyc;
            if (exp_q.size() == 0) fail_now("unexpected_output", n_out_seen);
            else begin
                e = exp_q.pop_front();
                check_rec("out_record", m_data, e.data);
                check("out_last", 64'(m_last), 64'(e.last));
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_ctrl"}, 64'({s_ready, m_valid, m_last, heap_en, heap_init, heap_in_end,
                                   heap_flush, busy, done, err_timeout}), 0);
        check({tag, "_data"}, 64'((|m_data) | (|heap_din)), 0);
    endtask

    // Reference: top-K by repeated selection of the earliest largest key.
    task automatic build_expect(input int topk, input int nacc, output int nout);
        logic [DW-1:0] pool[$];
        logic [DW-1:0] a, b;
        int best;
        exp_t e;
        for (int i = 0; i < nacc; i++) pool.push_back(recs[i]);
        nout = (topk < nacc) ? topk : nacc;
        for (int k = 0; k < nout; k++) begin
            best = 0;
            for (int j = 1; j < pool.size(); j++) begin
                a = pool[j];
                b = pool[best];
                if (a[KW-1:0] > b[KW-1:0]) best = j;
            end
            e.data = pool[best];
            e.last = (k == nout - 1);
            exp_q.push_back(e);
            pool.delete(best);
        end
    endtask

    task automatic run_job(input int topk, input int n, input bit with_last, input bit basic,
                           input bit tmo, input bit poke, input bit abort);
        int acc, guard, nout;
        int b_flush, b_en, b_init, b_inend, b_out;
        logic [DW-1:0] r;
        recs.delete();
        for (int i = 0; i < n; i++) begin
            r = '0;
            for (int w = 0; w < 9; w++) r[w*32 +: 32] = $urandom;
            r[KW +: 8] = 8'(i);
            r[KW-1:0]  = basic ? 7'(bkeys[i]) : 7'($urandom_range(0, 127));
            recs.push_back(r);
        end
        no_sort = tmo;
        b_flush = n_flush; b_en = n_en; b_init = n_init; b_inend = n_inend; b_out = n_out_seen;
        @(posedge clk); #1;
        start = 1'b1;
        cfg_topk = 16'(topk);
        @(posedge clk); #1;
        start = 1'b0;
        cfg_topk = 16'($urandom);
        @(negedge clk);
        check("busy_after_start", 64'(busy), 1);
        check("err_cleared_on_start", 64'(err_timeout), 0);
        @(posedge clk); #1;
        acc = 0;
        guard = 0;
        while (acc < n && acc < CAP && guard < 3000) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = recs[acc];
            s_last  = with_last && (acc == n - 1);
            if (poke && acc == 3) start = 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) acc++;
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
        end
        if (guard >= 3000) fail_now("load_stall", acc);
        nout = 0;
        if (!tmo) build_expect(topk, acc, nout);
        if (n > CAP) begin
            s_valid = 1'b1;
            s_data  = recs[CAP];
            @(negedge clk);
            check("s_ready_after_cap", 64'(s_ready), 0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (abort) begin
            guard = 0;
            while (n_flush - b_flush < 3 && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            check("flushes_before_abort", 64'(n_flush - b_flush >= 3), 1);
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            check_quiet("abort");
            rst = 1'b0;
            exp_q.delete();
            return;
        end
        guard = 0;
        while (guard < 1500) begin
            @(negedge clk);
            if (done) break;
            guard++;
        end
        if (!done) begin
            fail_now("done_timeout", guard);
        end else begin
            check("err_timeout", 64'(err_timeout), 64'(tmo));
            if (tmo) check("sort_cycles", 64'(cyc - inend_cyc), 1025);
            else if (nout > 0) check("done_latency", 64'(cyc - last_acc_cyc), 1);
            check("init_cycles", 64'(n_init - b_init), 2);
            check("en_beats", 64'(n_en - b_en), 64'(acc));
            check("in_end_pulses", 64'(n_inend - b_inend), 1);
            check("flush_count", 64'(n_flush - b_flush), 64'(nout));
            check("records_out", 64'(n_out_seen - b_out), 64'(nout));
            check("scoreboard_empty", 64'(exp_q.size()), 0);
            @(negedge clk);
            check("done_one_cycle", 64'(done), 0);
            check("idle_after_done", 64'(busy), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_topk = '0;
        s_data = '0;
        s_valid = 1'b0;
        s_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        rdy_mode = 0; run_job(4, 10, 1, 1, 0, 1, 0);
        rdy_mode = 1; run_job(4, 10, 1, 1, 0, 0, 0);
        rdy_mode = 2; run_job(100, 70, 0, 0, 0, 0, 0);
        rdy_mode = 0; run_job(8, 3, 1, 0, 0, 0, 0);
        run_job(0, 5, 1, 0, 0, 0, 0);
        run_job(4, 5, 1, 0, 1, 0, 0);
        run_job(3, 4, 1, 0, 0, 0, 0);
        rdy_mode = 2; run_job(20, 30, 1, 0, 0, 0, 1);
        run_job(5, 12, 1, 0, 0, 0, 0);
        for (int j = 0; j < 6; j++) begin
            int n, k;
            bit wl;
            n  = $urandom_range(1, 80);
            k  = $urandom_range(0, 70);
            wl = (n < CAP) ? 1'b1 : 1'($urandom_range(0, 1));
            rdy_mode = $urandom_range(0, 2);
            run_job(k, n, wl, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/heap_sort_ctrl.md
Name: heap_sort_ctrl

Overview:
- Sequencer for the two-sub-heap sorter (`heap_rtl`) in the keypoint-selection path.
- Runs one sort job per `start`:
  - clears the heap;
  - streams keypoint records into it under a valid/ready handshake;
  - signals end of input;
  - waits for the sort-complete pulse;
  - drains the top-K records through an output handshake with backpressure.
- Owns every heap control pin (`init`, `en`, `in_end`, `flush`). Upstream and downstream logic never drive the heap directly.

Parameters:
- DATA_WIDTH, 292: record width; key in bits [KEY_WIDTH-1:0].
- KEY_WIDTH, 7: key width; used only by the checker.
- NLEVELS, 6: heap levels. Capacity CAP = 2*(2^(NLEVELS-1)-1) = 62.
- CNT_WIDTH, 16: width of the input and output counters.
- SORT_TIMEOUT, 1024: maximum cycles to wait for `heap_sort_end`.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin job; ignored unless IDLE
- cfg_topk  in  CNT_WIDTH  records to emit; latched at start
- s_data  in  DATA_WIDTH  input record
- s_valid  in  1  input valid
- s_last  in  1  final input record
- s_ready  out  1  input ready
- m_data  out  DATA_WIDTH  output record
- m_valid  out  1  output valid
- m_last  out  1  final output record
- m_ready  in  1  output ready
- heap_din  out  DATA_WIDTH  to heap `din`
- heap_en  out  1  to heap `en`
- heap_init  out  1  to heap `init`
- heap_in_end  out  1  to heap `in_end`
- heap_flush  out  1  to heap `flush`
- heap_dout  in  DATA_WIDTH  from heap `dout` (combinational while flush is high)
- heap_sort_end  in  1  from heap `sort_end`
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err_timeout  out  1  sticky; cleared on start

Behaviour:
- Reset: state IDLE. All outputs 0. Counters 0. Output buffer empty. Reset mid-job aborts the job immediately; the next job's INIT clears the heap.
- FSM states: IDLE, INIT, LOAD, ENDP, SORT, FLUSH, DRAIN, DONE.
- IDLE: start=1 latches `cfg_topk`, clears `err_timeout` and counters, goes to INIT.
- INIT: `heap_init`=1 for exactly 2 cycles, then LOAD.
- LOAD:
  - `s_ready`=1. On accept (`s_valid & s_ready`): `heap_en`=1, `heap_din`=`s_data` in the same cycle (combinational pass-through); `in_cnt`++.
  - Leave to ENDP after accepting a beat with `s_last`=1, or after accepting the CAP-th beat. In the CAP case `s_ready` drops the next cycle and the remaining upstream beats stay pending for the caller.
  - Zero-length jobs are not supported: LOAD always waits for at least one accepted beat.
- ENDP: `heap_in_end`=1 for one cycle, then SORT. `heap_en` is never high in the same cycle as `heap_in_end`.
- SORT: wait for `heap_sort_end`=1, then FLUSH. After SORT_TIMEOUT cycles without it: set `err_timeout`, go to DONE, emit no data.
- Output count: N_OUT = min(`cfg_topk`, `in_cnt`). If N_OUT = 0, go FLUSH→DONE directly.
- FLUSH:
  - 1-entry output register.
  - `heap_flush`=1 in a cycle only if `out_cnt` < N_OUT and (register empty, or `m_valid & m_ready`).
  - In that cycle `heap_dout` is captured into `m_data`, `m_valid`=1 next cycle, and `out_cnt`++.
  - `m_last`=1 with the record where `out_cnt` = N_OUT.
  - `heap_flush` is never high while the register holds an unaccepted record.
  - After the last flush, go to DRAIN.
- DRAIN: hold `m_valid` until accepted, then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- `start` while busy is ignored.
- `m_valid`/`m_data`/`m_last` hold stable until accepted (AXI-stream rules).
- All counters saturate at CNT_WIDTH; `in_cnt` never exceeds CAP.

Decomposition:
- Package `heap_pkg`:
  - state enum encoding;
  - CAP as a function of NLEVELS;
  - `min()` helper;
  - key-extract function, shared with `heap_rtl`'s comparator.
- One sub-module, `heap_out_reg`: the 1-entry output register/handshake with capture-enable and can-accept outputs. It is reused by the FLUSH and DRAIN states.

Test Plan:
- Basic job: `cfg_topk`=4; 10 records with keys 3,9,1,7,5,8,2,6,4,0 (`s_last` on the 10th); `m_ready`=1. Expect:
  - two `heap_init` cycles, 10 `heap_en` beats, one `heap_in_end`, then 4 flushes;
  - `m_data` keys in heap drain order;
  - `m_last` on the 4th record, `done` one cycle after its acceptance.
- Backpressure: same job with `m_ready` toggling 1,0,0,1. Expect:
  - `heap_flush` high only when the register is empty or being accepted;
  - no record lost or duplicated; exactly 4 records out.
- Capacity: 70 records, no `s_last`. Expect:
  - `s_ready` low after the 62nd accept, `in_cnt`=62;
  - ENDP entered automatically;
  - `cfg_topk`=100 yields 62 records.
- Short input: `cfg_topk`=8, 3 records. Expect exactly 3 outputs with `m_last` on the 3rd. Separately, `cfg_topk`=0 → no output beats, `done` pulse.
- Timeout: hold `heap_sort_end`=0. Expect `err_timeout`=1 after 1024 SORT cycles, `done` pulse, `m_valid` never high; next `start` clears `err_timeout`.
- Reset and start: assert `rst` in the middle of FLUSH. Expect all outputs 0 next cycle and state IDLE; a new job then completes normally. `start` pulsed during LOAD is ignored.
